int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have parameter VEC_BASE, default 32'h0000_0100, giving the trap vector base address.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 15, giving the maximum number of cycles iack_n is held low.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 oint_n  in  3  interrupt request lines, level, active-low; bit0 has the highest priority.
REQ-006 int_en  in  1  global interrupt enable.
REQ-007 mret  in  1  one-cycle pulse from EX when mret executes.
REQ-008 mem_pending  in  1  MEM stage has an outstanding data access (dreq or dbusy active).
REQ-009 branch_PC_contral  in  1  taken branch resolved in MEM this cycle.
REQ-010 branch_PC  in  32  branch target.
REQ-011 resume_pc  in  32  PC of the oldest uncommitted instruction (EX stage).
REQ-012 int_stall  out  1  hold IF.
REQ-013 int_flush  out  1  nop IF/ID/EX.
REQ-014 int_redirect  out  1  one-cycle PC load.
REQ-015 int_pc  out  32  PC to load when int_redirect is high.
REQ-016 epc  out  32  saved return PC.
REQ-017 cause  out  2  latched line number (0..2).
REQ-018 iack_n  out  1  interrupt acknowledge, active-low.
REQ-019 in_handler  out  1  handler is executing.

Function
REQ-020 The FSM SHALL have the states IDLE, DRAIN, REDIRECT, ACK and HANDLER.
REQ-021 IDLE: when int_en=1 and any oint_n bit=0, the block SHALL latch cause from the lowest-numbered low bit and go to DRAIN on the next edge; otherwise it SHALL stay in IDLE.
REQ-022 On the IDLE->DRAIN edge, epc SHALL load branch_PC if branch_PC_contral=1, else resume_pc.
REQ-023 DRAIN: int_stall and int_flush SHALL be 1; a branch_PC_contral pulse during DRAIN SHALL overwrite epc with branch_PC; the block SHALL go to REDIRECT on the first cycle with mem_pending=0.
REQ-024 REDIRECT: int_redirect SHALL be 1 for exactly one cycle with int_pc equal to the vector address; int_stall SHALL stay 1; next state is ACK.
REQ-025 ACK: iack_n SHALL be 0 until oint_n[cause] reads 1 or ACK_TIMEOUT cycles elapse, whichever is first; the block then goes to HANDLER.
REQ-026 HANDLER: in_handler SHALL be 1 and all new requests SHALL be masked (no nesting).
REQ-027 HANDLER: an mret pulse SHALL produce int_redirect=1 for one cycle with int_pc=epc, and the block goes to IDLE.
REQ-028 mret outside HANDLER SHALL be ignored.
REQ-029 A request removed, or int_en dropped, after leaving IDLE SHALL NOT abort the sequence.
REQ-030 If mret and a pending request coincide in HANDLER, mret SHALL win; the request is taken from IDLE no earlier than the following cycle.
REQ-031 Minimum latency from request to int_redirect SHALL be 2 cycles (IDLE, DRAIN with mem_pending=0, then REDIRECT).
REQ-032 The ACK cycle counter SHALL be sized $clog2(ACK_TIMEOUT+1) bits and SHALL saturate, never wrap.

Reset
REQ-033 When rst=0, the block SHALL asynchronously enter IDLE with int_stall=0, int_flush=0, int_redirect=0, int_pc=0, epc=0, cause=0, iack_n=1, in_handler=0 and the counter at 0, including when reset occurs mid-sequence.

Configuration
REQ-034 With INT_VECTORED_EN defined, the vector address SHALL be VEC_BASE + 4*cause.
REQ-035 Without INT_VECTORED_EN, the vector address SHALL be VEC_BASE for all causes.

Structure
REQ-036 The state enum, cause encoding and VEC_BASE default SHALL live in the shared package int_pkg.
REQ-037 Priority encoding SHALL be a sub-module int_prio_enc (3-bit oint_n -> valid, 2-bit cause).

Verification
REQ-038 oint_n=3'b101, int_en=1, mem_pending=0, resume_pc=0x40 -> int_redirect 2 cycles later with int_pc=0x104 (vectored) or 0x100 (non-vectored); epc=0x40; cause=1.
REQ-039 oint_n=3'b000 -> cause=0; mem_pending held 1 for 5 cycles -> int_stall=1 and int_flush=1 for 6 cycles, redirect on the cycle after mem_pending falls.
REQ-040 Branch taken (branch_PC=0x200) during DRAIN -> epc=0x200; a later mret -> int_redirect with int_pc=0x200, state IDLE.
REQ-041 oint_n[0] held low -> iack_n low for exactly 15 cycles, then in_handler=1; a second request is ignored until mret.
REQ-042 rst asserted in ACK -> iack_n=1 and all outputs at reset values immediately; int_en=0 with oint_n=0 -> no state change.

Source files
------------

// File: rtl/int_pkg.sv
// -----------------------------------------------------------------------------
// int_pkg -- shared definitions for the interrupt controller.
//   state_e          : controller FSM states
//   cause_e          : encoding of the latched request line
//   VEC_BASE_DEFAULT : default trap vector base address
// -----------------------------------------------------------------------------
package int_pkg;

  localparam int          NUM_LINES        = 3;
  localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0100;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    REDIRECT,
    ACK,
    HANDLER
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_LINE0 = 2'd0,
    CAUSE_LINE1 = 2'd1,
    CAUSE_LINE2 = 2'd2
  } cause_e;

endpackage

// File: rtl/int_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc -- fixed-priority encoder for the active-low request lines.
// Ports:
//   oint_n [2:0] in  : request lines, active-low, bit0 highest priority
//   valid        out : at least one line is requesting
//   cause  [1:0] out : number of the highest-priority requesting line
// -----------------------------------------------------------------------------
module int_prio_enc
  import int_pkg::*;
(
  input  logic [2:0] oint_n,
  output logic       valid,
  output logic [1:0] cause
);

  assign valid = ~&oint_n;

  always_comb begin
    cause = CAUSE_LINE0;
    if (!oint_n[0])      cause = CAUSE_LINE0;
    else if (!oint_n[1]) cause = CAUSE_LINE1;
    else if (!oint_n[2]) cause = CAUSE_LINE2;
  end

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- single-level interrupt controller for the pipeline.
// Takes a request, drains the MEM stage, redirects fetch to the trap vector,
// acknowledges the source, and returns to the saved PC on mret. No nesting.
//
// Parameters:
//   VEC_BASE    : trap vector base address
//   ACK_TIMEOUT : maximum number of cycles iack_n is held low
// Build option:
//   INT_VECTORED_EN : vector address = VEC_BASE + 4*cause (else VEC_BASE)
//
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   oint_n[2:0]              : level request lines, active-low, bit0 first
//   int_en                   : global interrupt enable
//   mret                     : one-cycle return pulse from EX
//   mem_pending              : MEM stage has an outstanding data access
//   branch_PC_contral        : taken branch resolved in MEM this cycle
//   branch_PC[31:0]          : that branch's target
//   resume_pc[31:0]          : PC of the oldest uncommitted instruction
//   int_stall / int_flush    : hold IF / nop IF, ID, EX
//   int_redirect, int_pc     : one-cycle PC load and the PC to load
//   epc[31:0], cause[1:0]    : saved return PC and latched line number
//   iack_n                   : interrupt acknowledge, active-low
//   in_handler               : handler is executing
// -----------------------------------------------------------------------------
module int_ctrl
  import int_pkg::*;
#(
  parameter logic [31:0] VEC_BASE    = VEC_BASE_DEFAULT,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  oint_n,
  input  logic        int_en,
  input  logic        mret,
  input  logic        mem_pending,
  input  logic        branch_PC_contral,
  input  logic [31:0] branch_PC,
  input  logic [31:0] resume_pc,
  output logic        int_stall,
  output logic        int_flush,
  output logic        int_redirect,
  output logic [31:0] int_pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        iack_n,
  output logic        in_handler
);

  localparam int            CNT_W   = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

  state_e            state, state_next;
  logic [CNT_W-1:0]  ack_cnt, ack_cnt_next;
  logic              req_valid;
  logic [1:0]        req_cause;
  logic              line_released;
  logic              ack_last;
  logic [31:0]       vec_addr;

  int_prio_enc u_prio (
    .oint_n (oint_n),
    .valid  (req_valid),
    .cause  (req_cause)
  );

`ifdef INT_VECTORED_EN
  assign vec_addr = VEC_BASE + {28'd0, cause, 2'b00};
`else
  assign vec_addr = VEC_BASE;
`endif

  // The acknowledged source releases its line by driving it high again.
  always_comb begin
    case (cause)
      2'd0:    line_released = oint_n[0];
      2'd1:    line_released = oint_n[1];
      default: line_released = oint_n[2];
    endcase
  end

  // ack_cnt counts completed ACK cycles; this one is the last if it is the
  // ACK_TIMEOUT-th.
  assign ack_last = (32'(ack_cnt) + 32'd1) >= 32'(ACK_TIMEOUT);

  // NOTE: epc and cause are datapath registers but are still reset, because
  // their reset values are visible on the ports and must be deterministic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ack_cnt <= '0;
      epc     <= '0;
      cause   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state   <= state_next;
      ack_cnt <= ack_cnt_next;
      if (state == IDLE && int_en && req_valid) begin
        cause <= req_cause;
        epc   <= branch_PC_contral ? branch_PC : resume_pc;
      end else if (state == DRAIN && branch_PC_contral) begin
        // A branch resolving while draining is the true continuation point.
        epc <= branch_PC;
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_next   = state;
    ack_cnt_next = '0;
    int_stall    = 1'b0;
    int_flush    = 1'b0;
    int_redirect = 1'b0;
    int_pc       = '0;
    iack_n       = 1'b1;
    in_handler   = 1'b0;

    case (state)
      IDLE: begin
        if (int_en && req_valid) state_next = DRAIN;
      end
      DRAIN: begin
        int_stall = 1'b1;
        int_flush = 1'b1;
        if (!mem_pending) state_next = REDIRECT;
      end
      REDIRECT: begin
        int_stall    = 1'b1;
        int_redirect = 1'b1;
        int_pc       = vec_addr;
        state_next   = ACK;
      end
      ACK: begin
        iack_n = 1'b0;
        if (line_released || ack_last) begin
          state_next = HANDLER;
        end else begin
          ack_cnt_next = (ack_cnt == CNT_MAX) ? ack_cnt : ack_cnt + CNT_W'(1);
        end
      end
      HANDLER: begin
        in_handler = 1'b1;
        // Requests are masked here; mret always wins over a pending line.
        if (mret) begin
          int_redirect = 1'b1;
          int_pc       = epc;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl -- self-checking bench for int_ctrl.
// Each interrupt is described as a transaction (request pattern, drain length,
// branch position, release time, handler length); the expected per-cycle
// outputs are derived from those transaction parameters.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  localparam logic [31:0] VEC_BASE    = 32'h0000_0100;
  localparam int          ACK_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  oint_n;
  logic        int_en;
  logic        mret;
  logic        mem_pending;
  logic        branch_PC_contral;
  logic [31:0] branch_PC;
  logic [31:0] resume_pc;
  logic        int_stall;
  logic        int_flush;
  logic        int_redirect;
  logic [31:0] int_pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        iack_n;
  logic        in_handler;

  int n_checks = 0;
  int n_fail   = 0;

  int_ctrl #(
    .VEC_BASE    (VEC_BASE),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .oint_n            (oint_n),
    .int_en            (int_en),
    .mret              (mret),
    .mem_pending       (mem_pending),
    .branch_PC_contral (branch_PC_contral),
    .branch_PC         (branch_PC),
    .resume_pc         (resume_pc),
    .int_stall         (int_stall),
    .int_flush         (int_flush),
    .int_redirect      (int_redirect),
    .int_pc            (int_pc),
    .epc               (epc),
    .cause             (cause),
    .iack_n            (iack_n),
    .in_handler        (in_handler)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Highest-priority requesting line: the lowest-numbered bit that is low.
  function automatic int cause_of(input logic [2:0] r);
    for (int i = 0; i < 3; i++) if (!r[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] vec_of(input int c);
`ifdef INT_VECTORED_EN
    return VEC_BASE + 32'(4 * c);
`else
    return VEC_BASE + 32'(0 * c);
`endif
  endfunction

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string ph, input logic stall, input logic flush,
                            input logic redir, input logic iack, input logic inh);
    check({ph, ".int_stall"},    32'(int_stall),    32'(stall));
    check({ph, ".int_flush"},    32'(int_flush),    32'(flush));
    check({ph, ".int_redirect"}, 32'(int_redirect), 32'(redir));
    check({ph, ".iack_n"},       32'(iack_n),       32'(iack));
    check({ph, ".in_handler"},   32'(in_handler),   32'(inh));
  endtask

  task automatic check_reset_outs(input string ph);
    check_outs(ph, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check({ph, ".int_pc"}, int_pc, 32'h0);
    check({ph, ".epc"},    epc,    32'h0);
    check({ph, ".cause"},  32'(cause), 32'h0);
  endtask

  task automatic randomize_side_inputs();
    mret              = 1'($urandom);
    mem_pending       = 1'($urandom);
    branch_PC_contral = 1'($urandom);
    branch_PC         = $urandom;
    resume_pc         = $urandom;
  endtask

  // Idle cycles: either int_en low with arbitrary lines, or int_en high with
  // no line requesting. Stray mret pulses must be ignored.
  task automatic idle_cycles(input int n, input bit en, input bit all_low);
    for (int i = 0; i < n; i++) begin
      randomize_side_inputs();
      int_en = en;
      oint_n = all_low ? 3'b000 : (en ? 3'b111 : 3'($urandom));
      sample();
      check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      next_cycle();
    end
  endtask

  // One full interrupt transaction starting in IDLE.
  //   br_cyc  : drain cycle index carrying a branch (-1: none)
  //   rel_cyc : ACK cycle index at which the line reads high (large: never)
  //   rst_at  : ACK cycle index at which reset is applied (-1: none)
  task automatic run_txn(input logic [2:0] req, input logic [31:0] rp, input bit br_entry,
                         input logic [31:0] br_tgt, input int drain_len, input int br_cyc,
                         input int rel_cyc, input int hdl_len, input int rst_at);
    int          c;
    int          ack_len;
    logic [31:0] e_epc;
    logic [2:0]  o;

    c = cause_of(req);

    // Request cycle (IDLE).
    randomize_side_inputs();
    oint_n            = req;
    int_en            = 1'b1;
    resume_pc         = rp;
    branch_PC_contral = br_entry;
    branch_PC         = br_entry ? br_tgt : $urandom;
    e_epc             = br_entry ? br_tgt : rp;
    sample();
    check_outs("req", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();

    // Drain: request and enable may vanish without aborting the sequence.
    for (int j = 0; j <= drain_len; j++) begin
      randomize_side_inputs();
      oint_n            = 3'($urandom);
      int_en            = 1'($urandom);
      mem_pending       = (j < drain_len);
      branch_PC_contral = (j == br_cyc);
      if (j == br_cyc) begin
        branch_PC = br_tgt;
        e_epc     = br_tgt;
      end
      sample();
      check_outs("drain", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      next_cycle();
    end

    // Redirect to the vector.
    randomize_side_inputs();
    oint_n = 3'($urandom);
    int_en = 1'($urandom);
    sample();
    check_outs("vector", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("vector.int_pc", int_pc, vec_of(c));
    check("vector.cause",  32'(cause), 32'(c));
    check("vector.epc",    epc, e_epc);
    next_cycle();

    // Acknowledge.
    ack_len = (rel_cyc + 1 < ACK_TIMEOUT) ? rel_cyc + 1 : ACK_TIMEOUT;
    for (int k = 0; k < ack_len; k++) begin
      randomize_side_inputs();
      int_en = 1'($urandom);
      o      = 3'($urandom);
      o[c]   = (k >= rel_cyc);
      oint_n = o;
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1 check_reset_outs("rst_async");
        next_cycle();
        check_reset_outs("rst_held");
        rst    = 1'b1;
        int_en = 1'b0;
        oint_n = 3'b111;
        mret   = 1'b0;
        sample();
        check_reset_outs("rst_release");
        next_cycle();
        return;
      end
      sample();
      check_outs("ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end

    // Handler: new requests are masked; stray branches do not touch epc.
    for (int h = 0; h < hdl_len; h++) begin
      randomize_side_inputs();
      mret   = 1'b0;
      int_en = 1'b1;
      oint_n = 3'($urandom);
      sample();
      check_outs("handler", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("handler.epc",   epc, e_epc);
      check("handler.cause", 32'(cause), 32'(c));
      next_cycle();
    end

    // Return; a pending request in the same cycle loses to mret.
    randomize_side_inputs();
    mret   = 1'b1;
    int_en = 1'b1;
    oint_n = 3'($urandom);
    sample();
    check_outs("mret", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("mret.int_pc", int_pc, e_epc);
    next_cycle();
    mret = 1'b0;
  endtask

  initial begin
    int          drain_len;
    int          br_cyc;
    int          rel_cyc;
    int          hdl_len;
    int          rst_at;
    logic [2:0]  req;

    rst               = 1'b0;
    oint_n            = 3'b111;
    int_en            = 1'b0;
    mret              = 1'b0;
    mem_pending       = 1'b0;
    branch_PC_contral = 1'b0;
    branch_PC         = '0;
    resume_pc         = '0;

    #3;
    check_reset_outs("reset");
    next_cycle();
    next_cycle();
    rst = 1'b1;

    // Disabled with every line requesting: nothing happens.
    idle_cycles(3, 1'b0, 1'b1);
    idle_cycles(2, 1'b1, 1'b0);

    // Line 1, no drain, resume at 0x40.
    run_txn(3'b101, 32'h40, 1'b0, 32'h0, 0, -1, 0, 2, -1);
    // All lines low, five-cycle drain.
    run_txn(3'b000, 32'h1000, 1'b0, 32'h0, 5, -1, 1, 1, -1);
    // Branch to 0x200 during drain becomes the return PC.
    run_txn(3'b011, 32'h80, 1'b0, 32'h200, 2, 1, 0, 1, -1);
    // Branch resolved on the request cycle itself.
    run_txn(3'b110, 32'h84, 1'b1, 32'h300, 0, -1, 2, 0, -1);
    // Line 0 never released: ACK times out; further requests masked.
    run_txn(3'b110, 32'h500, 1'b0, 32'h0, 1, -1, 1000, 4, -1);
    // Reset in the middle of ACK.
    run_txn(3'b011, 32'h600, 1'b0, 32'h0, 0, -1, 1000, 2, 3);
    idle_cycles(2, 1'b0, 1'b1);

    // Randomized transactions, sometimes back to back.
    for (int t = 0; t < 40; t++) begin
      do req = 3'($urandom); while (req == 3'b111);
      drain_len = $urandom_range(0, 4);
      br_cyc    = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, drain_len);
      rel_cyc   = ($urandom_range(0, 3) == 0) ? 1000 : $urandom_range(0, 6);
      hdl_len   = $urandom_range(0, 4);
      rst_at    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
      run_txn(req, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 3) == 0),
              $urandom & 32'hFFFF_FFFC, drain_len, br_cyc, rel_cyc, hdl_len, rst_at);
      idle_cycles($urandom_range(0, 2), 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
